// File: rtl/exec_unit_pkg.sv
// exec_unit_pkg: shared constants for the execute stage.
//   EXEC        - value of the pipeline phase input in which EX advances
//   opcode_t    - 5-bit opcode encodings (ir[IR_WIDTH-1:IR_WIDTH-5]), incl. OP_MUL
//   fsm_t       - execute-stage sequencer states (IDLE, MUL)
//   updates_flags() - opcodes whose result writes zf/sf/cf
package exec_unit_pkg;

  localparam logic EXEC = 1'b1;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,  OP_HALT  = 5'd1,  OP_LOAD  = 5'd2,  OP_STORE = 5'd3,
    OP_LDIH  = 5'd4,  OP_ADD   = 5'd5,  OP_ADDI  = 5'd6,  OP_ADDC  = 5'd7,
    OP_SUB   = 5'd8,  OP_SUBI  = 5'd9,  OP_SUBC  = 5'd10, OP_CMP   = 5'd11,
    OP_AND   = 5'd12, OP_OR    = 5'd13, OP_XOR   = 5'd14, OP_SLL   = 5'd15,
    OP_SRL   = 5'd16, OP_SLA   = 5'd17, OP_SRA   = 5'd18, OP_JUMP  = 5'd19,
    OP_JMPR  = 5'd20, OP_BZ    = 5'd21, OP_BNZ   = 5'd22, OP_BN    = 5'd23,
    OP_BNN   = 5'd24, OP_BC    = 5'd25, OP_BNC   = 5'd26, OP_MUL   = 5'd27
  } opcode_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } fsm_t;

  function automatic logic updates_flags(opcode_t op);
    return op inside {OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP};
  endfunction

endpackage

// File: rtl/exec_unit_alu.sv
// alu_param: combinational ALU of the execute stage.
//   ex_ir   in  instruction (opcode in top 5 bits)
//   reg_A   in  operand A
//   reg_B   in  operand B (low clog2(WIDTH) bits are the shift amount)
//   cfin    in  carry/borrow in for ADDC/SUBC
//   cfout   out carry-out (add) or borrow-out (subtract), 0 otherwise
//   alu_out out result; 0 for opcodes without a datapath result (incl. MUL)
module alu_param #(
  parameter int WIDTH    = 16,
  parameter int IR_WIDTH = 16
) (
  input  logic [IR_WIDTH-1:0] ex_ir,
  input  logic [WIDTH-1:0]    reg_A,
  input  logic [WIDTH-1:0]    reg_B,
  input  logic                cfin,
  output logic                cfout,
  output logic [WIDTH-1:0]    alu_out
);
  import exec_unit_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  opcode_t        op;
  logic [SHW-1:0] sh;
  logic [WIDTH:0] ext;
  logic           unused_bits;

  assign op          = opcode_t'(ex_ir[IR_WIDTH-1 -: 5]);
  assign sh          = reg_B[SHW-1:0];
  assign unused_bits = ^{ex_ir[IR_WIDTH-6:0], reg_B[WIDTH-1:SHW]};

  // Subtraction is done zero-extended, so ext[WIDTH] is the borrow.
  always_comb begin
    ext     = '0;
    alu_out = '0;
    cfout   = 1'b0;
    case (op)
      OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: begin
        ext     = {1'b0, reg_A} + {1'b0, reg_B};
        alu_out = ext[WIDTH-1:0];
        cfout   = ext[WIDTH];
      end
      OP_ADDC: begin
        ext     = {1'b0, reg_A} + {1'b0, reg_B} + {{WIDTH{1'b0}}, cfin};
        alu_out = ext[WIDTH-1:0];
        cfout   = ext[WIDTH];
      end
      OP_SUB, OP_SUBI, OP_CMP: begin
        ext     = {1'b0, reg_A} - {1'b0, reg_B};
        alu_out = ext[WIDTH-1:0];
        cfout   = ext[WIDTH];
      end
      OP_SUBC: begin
        ext     = {1'b0, reg_A} - {1'b0, reg_B} - {{WIDTH{1'b0}}, cfin};
        alu_out = ext[WIDTH-1:0];
        cfout   = ext[WIDTH];
      end
      OP_AND:          alu_out = reg_A & reg_B;
      OP_OR:           alu_out = reg_A | reg_B;
      OP_XOR:          alu_out = reg_A ^ reg_B;
      OP_SLL, OP_SLA:  alu_out = reg_A << sh;
      OP_SRL:          alu_out = reg_A >> sh;
      OP_SRA:          alu_out = $unsigned($signed(reg_A) >>> sh);
      OP_LDIH:         alu_out = reg_B;
      default:         alu_out = '0;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: pipeline EX stage with optional multi-cycle shift-add multiplier.
// Build option: define EXEC_UNIT_MUL_EN to include the MUL sequencer; when
// undefined, MUL is a single-cycle op giving reg_C=0 and busy is tied 0.
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   state          pipeline phase; registers advance only when state == EXEC
//   ex_ir          instruction in EX (held upstream while busy)
//   reg_A, reg_B   operands;  smdr  store data
//   jump           flush: bubble into MEM, abort MUL, keep reg_C/flags
//   alu_out        combinational ALU result
//   mem_ir         instruction to MEM (0 = bubble)
//   reg_C          registered result;  zf, sf, cf  registered flags
//   dw, smdr1      MEM write strobe and registered store data
//   busy           MUL in progress
module exec_unit #(
  parameter int WIDTH    = 16,
  parameter int IR_WIDTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                state,
  input  logic [IR_WIDTH-1:0] ex_ir,
  input  logic [WIDTH-1:0]    reg_A,
  input  logic [WIDTH-1:0]    reg_B,
  input  logic [WIDTH-1:0]    smdr,
  input  logic                jump,
  output logic [WIDTH-1:0]    alu_out,
  output logic [IR_WIDTH-1:0] mem_ir,
  output logic [WIDTH-1:0]    reg_C,
  output logic                zf,
  output logic                sf,
  output logic                cf,
  output logic                dw,
  output logic [WIDTH-1:0]    smdr1,
  output logic                busy
);
  import exec_unit_pkg::*;

  opcode_t op;
  logic    alu_cf;

  assign op = opcode_t'(ex_ir[IR_WIDTH-1 -: 5]);

  alu_param #(.WIDTH(WIDTH), .IR_WIDTH(IR_WIDTH)) u_alu (
    .ex_ir   (ex_ir),
    .reg_A   (reg_A),
    .reg_B   (reg_B),
    .cfin    (cf),
    .cfout   (alu_cf),
    .alu_out (alu_out)
  );

`ifdef EXEC_UNIT_MUL_EN
  localparam int CW = $clog2(WIDTH);

  fsm_t               fsm;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_next;

  // One shift-add step: the multiplicand shifts left while the multiplier
  // shifts right, so mplier[0] always selects the current partial product.
  assign acc_next = mplier[0] ? acc + mcand : acc;
  assign busy     = (fsm == MUL);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_ir <= '0;
      reg_C  <= '0;
      zf     <= 1'b0;
      sf     <= 1'b0;
      cf     <= 1'b0;
      dw     <= 1'b0;
      smdr1  <= '0;
`ifdef EXEC_UNIT_MUL_EN
      fsm    <= IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
`endif
    end else if (state == EXEC) begin
      // Only a STORE issuing this cycle drives a memory write.
      dw    <= 1'b0;
      smdr1 <= '0;
      if (jump) begin
        mem_ir <= '0;
`ifdef EXEC_UNIT_MUL_EN
        fsm    <= IDLE;
`endif
      end
`ifdef EXEC_UNIT_MUL_EN
      else if (fsm == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        if (count == CW'(WIDTH - 1)) begin
          reg_C  <= acc_next[WIDTH-1:0];
          zf     <= (acc_next[WIDTH-1:0] == '0);
          sf     <= acc_next[WIDTH-1];
          cf     <= |acc_next[2*WIDTH-1:WIDTH];
          mem_ir <= ex_ir;
          fsm    <= IDLE;
        end else begin
          mem_ir <= '0;
        end
      end else if (op == OP_MUL) begin
        mcand  <= {{WIDTH{1'b0}}, reg_A};
        mplier <= reg_B;
        acc    <= '0;
        count  <= '0;
        mem_ir <= '0;
        fsm    <= MUL;
      end
`endif
      else begin
        mem_ir <= ex_ir;
        reg_C  <= alu_out;
        if (updates_flags(op)) begin
          zf <= (alu_out == '0);
          sf <= alu_out[WIDTH-1];
          cf <= alu_cf;
        end
        if (op == OP_STORE) begin
          dw    <= 1'b1;
          smdr1 <= smdr;
        end
      end
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: randomized self-checking bench for exec_unit (WIDTH=16).
// Reference model works at instruction level: ALU results from integer
// arithmetic, MUL as a product captured at acceptance plus a cycle countdown.
module tb_exec_unit;
  import exec_unit_pkg::*;

  localparam int W   = 16;
  localparam int IRW = 16;
`ifdef EXEC_UNIT_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           state = 1'b0;
  logic [IRW-1:0] ex_ir = '0;
  logic [W-1:0]   reg_A = '0;
  logic [W-1:0]   reg_B = '0;
  logic [W-1:0]   smdr  = '0;
  logic           jump  = 1'b0;
  logic [W-1:0]   alu_out;
  logic [IRW-1:0] mem_ir;
  logic [W-1:0]   reg_C;
  logic           zf, sf, cf, dw, busy;
  logic [W-1:0]   smdr1;

  exec_unit #(.WIDTH(W), .IR_WIDTH(IRW)) dut (
    .clock(clock), .reset(reset), .state(state), .ex_ir(ex_ir),
    .reg_A(reg_A), .reg_B(reg_B), .smdr(smdr), .jump(jump),
    .alu_out(alu_out), .mem_ir(mem_ir), .reg_C(reg_C), .zf(zf), .sf(sf),
    .cf(cf), .dw(dw), .smdr1(smdr1), .busy(busy)
  );

  always #5 clock = ~clock;

  // reference model state
  logic [IRW-1:0] m_memir;
  logic [W-1:0]   m_regc, m_smdr1;
  logic           m_zf, m_sf, m_cf, m_dw;
  int             m_left;
  logic [2*W-1:0] m_prod;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_arith(input logic [4:0] op);
    return op == OP_ADD || op == OP_ADDI || op == OP_ADDC || op == OP_SUB ||
           op == OP_SUBI || op == OP_SUBC || op == OP_CMP;
  endfunction

  function automatic void alu_ref(input logic [IRW-1:0] ir, input logic [W-1:0] a, b,
                                  input logic cin, output logic [W-1:0] res, output logic cout);
    int unsigned ua, ub, uc, sh, r;
    logic [4:0]  op;
    ua = a; ub = b; uc = cin; sh = b % W; r = 0; cout = 1'b0;
    op = ir[IRW-1 -: 5];
    case (op)
      OP_ADD, OP_ADDI, OP_LOAD, OP_STORE: begin r = ua + ub; cout = ((r >> W) & 1) != 0; end
      OP_ADDC: begin r = ua + ub + uc; cout = ((r >> W) & 1) != 0; end
      OP_SUB, OP_SUBI, OP_CMP: begin r = ua - ub; cout = ua < ub; end
      OP_SUBC: begin r = ua - ub - uc; cout = ua < ub + uc; end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_SLL, OP_SLA: r = ua << sh;
      OP_SRL: r = ua >> sh;
      OP_SRA: r = (ua >> sh) | (a[W-1] ? (32'hFFFF_FFFF << (W - sh)) : 0);
      OP_LDIH: r = ub;
      default: r = 0;
    endcase
    res = W'(r);
  endfunction

  function automatic void model_reset();
    m_memir = '0; m_regc = '0; m_smdr1 = '0;
    m_zf = 0; m_sf = 0; m_cf = 0; m_dw = 0;
    m_left = 0; m_prod = '0;
  endfunction

  function automatic void model_edge(input logic st, input logic [IRW-1:0] ir,
                                     input logic [W-1:0] a, b, sm, input logic jmp);
    logic [W-1:0] res;
    logic         c;
    logic [4:0]   op;
    if (!st) return;
    op = ir[IRW-1 -: 5];
    m_dw = 0; m_smdr1 = '0;
    if (jmp) begin
      m_memir = '0;
      m_left  = 0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_regc  = m_prod[W-1:0];
        m_zf    = (m_prod[W-1:0] == 0);
        m_sf    = m_prod[W-1];
        m_cf    = (m_prod[2*W-1:W] != 0);
        m_memir = ir;
      end else begin
        m_memir = '0;
      end
    end else if (MUL_ON && op == OP_MUL) begin
      m_prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      m_left  = W;
      m_memir = '0;
    end else begin
      alu_ref(ir, a, b, m_cf, res, c);
      m_memir = ir;
      m_regc  = res;
      if (is_arith(op)) begin
        m_zf = (res == 0); m_sf = res[W-1]; m_cf = c;
      end
      if (op == OP_STORE) begin m_dw = 1; m_smdr1 = sm; end
    end
  endfunction

  task automatic check_outputs();
    check_eq("mem_ir", mem_ir, m_memir);
    check_eq("reg_C",  reg_C,  m_regc);
    check_eq("zf",     zf,     m_zf);
    check_eq("sf",     sf,     m_sf);
    check_eq("cf",     cf,     m_cf);
    check_eq("dw",     dw,     m_dw);
    check_eq("smdr1",  smdr1,  m_smdr1);
    check_eq("busy",   busy,   m_left != 0);
  endtask

  task automatic step(input logic st, input logic [IRW-1:0] ir,
                      input logic [W-1:0] a, b, sm, input logic jmp);
    logic [W-1:0] ea;
    logic         ec;
    @(negedge clock);
    state = st; ex_ir = ir; reg_A = a; reg_B = b; smdr = sm; jump = jmp;
    #1;
    alu_ref(ir, a, b, m_cf, ea, ec);
    check_eq("alu_out", alu_out, ea);
    check_eq("busy_comb", busy, m_left != 0);
    @(posedge clock);
    model_edge(st, ir, a, b, sm, jmp);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic logic [IRW-1:0] mk_ir(input logic [4:0] op);
    logic [10:0] lo;
    lo = 11'($urandom);
    return {op, lo};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Issues a MUL and clocks it to completion; the exec phase drops every
  // third cycle when toggle is set.
  task automatic mul_run(input logic [W-1:0] a, b, input bit toggle,
                         output int exec_n, output int total_n);
    logic [IRW-1:0] ir;
    logic           st;
    ir = mk_ir(OP_MUL);
    step(1'b1, ir, a, b, '0, 1'b0);
    if (MUL_ON) check_eq("mul_busy_rise", busy, 1);
    exec_n = 0; total_n = 0;
    while (mem_ir !== ir && total_n < 4 * W) begin
      st = toggle ? (total_n % 3 != 2) : 1'b1;
      step(st, ir, pick(), pick(), W'($urandom), 1'b0);
      total_n++;
      if (st) exec_n++;
    end
    check_eq("mul_mem_ir", mem_ir, ir);
  endtask

  initial begin
    logic [IRW-1:0] ir;
    logic [4:0]     op;
    logic [W-1:0]   saved;
    int             en, tn;

    model_reset();
    #2 reset = 1'b0;
    #1 check_outputs();
    @(negedge clock);
    reset = 1'b1;

    // ADD overflow into sign bit
    ir = mk_ir(OP_ADD);
    step(1, ir, 16'h7FFF, 16'h0001, '0, 0);
    check_eq("add_regc", reg_C, 16'h8000);
    check_eq("add_sf", sf, 1);
    check_eq("add_zf", zf, 0);
    check_eq("add_cf", cf, 0);
    check_eq("add_mem_ir", mem_ir, ir);

    // SUB to zero, then STORE keeps flags
    step(1, mk_ir(OP_SUB), 16'h0005, 16'h0005, '0, 0);
    check_eq("sub_regc", reg_C, 0);
    check_eq("sub_zf", zf, 1);
    step(1, mk_ir(OP_STORE), 16'h0010, 16'h0002, 16'hBEEF, 0);
    check_eq("store_dw", dw, 1);
    check_eq("store_smdr1", smdr1, 16'hBEEF);
    check_eq("store_zf_held", zf, 1);
    step(1, mk_ir(OP_AND), 16'h00F0, 16'h0FF0, 16'h1234, 0);
    check_eq("dw_clear", dw, 0);
    check_eq("and_regc", reg_C, 16'h00F0);

    // 3*5
    mul_run(16'd3, 16'd5, 1'b0, en, tn);
    check_eq("mul_latency", en, MUL_ON ? W : 0);
    check_eq("mul_regc", reg_C, MUL_ON ? 16'h000F : 16'h0000);
    check_eq("mul_busy_end", busy, 0);
    if (MUL_ON) begin
      check_eq("mul_cf", cf, 0);
      check_eq("mul_zf", zf, 0);
    end

    // 0x100*0x100 with exec phase toggling
    mul_run(16'h0100, 16'h0100, 1'b1, en, tn);
    if (MUL_ON) begin
      check_eq("mul2_exec_cycles", en, W);
      check_eq("mul2_total_cycles", tn, 3 * (W / 2) - 1);
      check_eq("mul2_regc", reg_C, 0);
      check_eq("mul2_zf", zf, 1);
      check_eq("mul2_cf", cf, 1);
    end

    // flush at MUL step 5
    ir = mk_ir(OP_MUL);
    step(1, ir, 16'd7, 16'd9, '0, 0);
    for (int i = 0; i < 4; i++) step(1, ir, pick(), pick(), '0, 0);
    saved = m_regc;
    step(1, ir, pick(), pick(), '0, 1);
    check_eq("jump_mem_ir", mem_ir, 0);
    check_eq("jump_busy", busy, 0);
    check_eq("jump_regc", reg_C, saved);

    // reset mid-MUL, then a new op accepted on the first exec cycle
    step(1, ir, 16'd11, 16'd13, '0, 0);
    for (int i = 0; i < 3; i++) step(1, ir, pick(), pick(), '0, 0);
    do_reset();
    ir = mk_ir(OP_ADD);
    step(1, ir, 16'd1, 16'd2, '0, 0);
    check_eq("post_reset_mem_ir", mem_ir, ir);
    check_eq("post_reset_regc", reg_C, 16'd3);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      if (m_left != 0) begin
        ir = ex_ir;
      end else begin
        op = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 5) == 0) op = OP_MUL;
        ir = mk_ir(op);
      end
      step($urandom_range(0, 4) != 0, ir, pick(), pick(), W'($urandom),
           $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
